// File: rtl/ex_muldiv_unit.sv
// ---- ex_muldiv_unit : iterative RV32M multiply/divide for the EX stage ----
// ---- rev 1.0 : shift-add multiply, restoring divide, 1-cycle div fast paths ----
`default_nettype none

module ex_muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start_i,
   input  logic            flush_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic [4:0]      addr_rd_i,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      addr_rd_o,
   output logic            done_o,
   output logic            busy_o,
   output logic            stall_o
);

   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]        state, state_nxt;
   logic [CW-1:0]     cnt;
   logic [2:0]        op;
   logic [4:0]        rd;
   logic              neg;
   logic [XLEN-1:0]   mcand, divisor, quo;
   logic [XLEN:0]     rem;
   logic [2*XLEN-1:0] acc;

   logic            accept, sgn_a, sgn_b, a_neg, b_neg, div_zero, ovf, fast, last;
   logic [XLEN-1:0] a_abs, b_abs, fast_res;

   assign accept   = start_i && !flush_i;
   assign sgn_a    = funct3_i[2] ? !funct3_i[0] : (funct3_i[1:0] != 2'b11);
   assign sgn_b    = funct3_i[2] ? !funct3_i[0] : !funct3_i[1];
   assign a_neg    = sgn_a && rs1_i[XLEN-1];
   assign b_neg    = sgn_b && rs2_i[XLEN-1];
   assign a_abs    = a_neg ? -rs1_i : rs1_i;
   assign b_abs    = b_neg ? -rs2_i : rs2_i;
   assign div_zero = (rs2_i == '0);
   assign ovf      = !funct3_i[0] && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
   assign fast     = funct3_i[2] && (div_zero || ovf);
   // Divide-by-zero outranks overflow; the two cannot coincide anyway.
   assign fast_res = div_zero ? (funct3_i[1] ? rs1_i : '1)
                              : (funct3_i[1] ? '0 : rs1_i);
   assign last     = (cnt == CW'(XLEN - 1));

   logic [XLEN:0]     msum, shifted, diff, rem_nxt;
   logic [2*XLEN-1:0] acc_nxt, prod_fix;
   logic [XLEN-1:0]   quo_nxt, mul_res, div_raw, div_res, final_res;

   // One shift-add and one shift-subtract step per cycle; op decides which is kept.
   assign msum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
   assign acc_nxt   = {msum, acc[XLEN-1:1]};
   assign shifted   = {rem[XLEN-1:0], quo[XLEN-1]};
   assign diff      = shifted - {1'b0, divisor};
   assign rem_nxt   = diff[XLEN] ? shifted : diff;
   assign quo_nxt   = {quo[XLEN-2:0], !diff[XLEN]};
   assign prod_fix  = neg ? -acc_nxt : acc_nxt;
   assign mul_res   = (op[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
   assign div_raw   = op[1] ? rem_nxt[XLEN-1:0] : quo_nxt;
   assign div_res   = neg ? -div_raw : div_raw;
   assign final_res = op[2] ? div_res : mul_res;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = fast ? DONE : CALC;
         CALC:    if (flush_i) state_nxt = IDLE;
                  else if (last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy_o  = (state != IDLE);
      done_o  = (state == DONE);
      stall_o = ((state == IDLE) && accept) || (state == CALC);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         op        <= '0;
         rd        <= '0;
         neg       <= 1'b0;
         mcand     <= '0;
         divisor   <= '0;
         quo       <= '0;
         rem       <= '0;
         acc       <= '0;
         result_o  <= '0;
         addr_rd_o <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               op      <= funct3_i;
               rd      <= addr_rd_i;
               neg     <= (funct3_i[2] && funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
               cnt     <= '0;
               mcand   <= a_abs;
               acc     <= {{XLEN{1'b0}}, b_abs};
               divisor <= b_abs;
               quo     <= a_abs;
               rem     <= '0;
               if (fast) begin
                  result_o  <= fast_res;
                  addr_rd_o <= addr_rd_i;
               end
            end
            CALC: if (!flush_i) begin
               cnt <= cnt + CW'(1);
               acc <= acc_nxt;
               rem <= rem_nxt;
               quo <= quo_nxt;
               if (last) begin
                  result_o  <= final_res;
                  addr_rd_o <= rd;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
// ---- tb_ex_muldiv_unit : directed + random checks of ex_muldiv_unit against an arithmetic model ----
`default_nettype none

module tb_ex_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] rs1 = '0;
   logic [31:0] rs2 = '0;
   logic [4:0]  rd_in = '0;
   logic [31:0] result;
   logic [4:0]  rd_out;
   logic        done, busy, stall;

   int checks = 0;
   int errors = 0;
   logic [31:0] last_res = '0;
   logic [4:0]  last_rd = '0;

   ex_muldiv_unit #(.XLEN(32)) dut (
      .clk(clk), .reset(reset), .start_i(start), .flush_i(flush),
      .funct3_i(funct3), .rs1_i(rs1), .rs2_i(rs2), .addr_rd_i(rd_in),
      .result_o(result), .addr_rd_o(rd_out), .done_o(done),
      .busy_o(busy), .stall_o(stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint p;
      logic [63:0] u;
      int sa, sb, q;
      sa = a;
      sb = b;
      case (f3)
         3'd0: begin p = longint'(sa) * longint'(sb); return p[31:0]; end
         3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
         3'd2: begin p = longint'(sa) * longint'({32'b0, b}); return p[63:32]; end
         3'd3: begin u = {32'b0, a} * {32'b0, b}; return u[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            q = sa / sb; return q;
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            q = sa % sb; return q;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      logic [31:0] exp;
      int explat, lat;
      logic stall_bad;
      exp    = ref_model(f3, a, b);
      explat = (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 0 : 32;
      @(negedge clk);
      start = 1'b1; funct3 = f3; rs1 = a; rs2 = b; rd_in = rd;
      #1 chk("stall_req", {31'b0, stall}, 32'd1);
      @(posedge clk); #1;
      start = 1'b0; rs1 = $urandom; rs2 = $urandom; rd_in = 5'($urandom);
      lat = 0; stall_bad = 1'b0;
      while (done !== 1'b1 && lat < 100) begin
         if (stall !== 1'b1) stall_bad = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", lat, explat);
      chk("stall_calc", {31'b0, stall_bad}, 32'd0);
      chk("result", result, exp);
      chk("rd", {27'b0, rd_out}, {27'b0, rd});
      chk("stall_done", {31'b0, stall}, 32'd0);
      @(posedge clk); #1;
      chk("done_clr", {31'b0, done}, 32'd0);
      chk("busy_clr", {31'b0, busy}, 32'd0);
      chk("result_hold", result, exp);
      last_res = exp;
      last_rd  = rd;
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic [2:0]  rf;
      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_result", result, 32'd0);
      chk("rst_rd", {27'b0, rd_out}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      reset = 1'b0;

      // directed cases
      do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd11);
      do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1);
      do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
      do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3);
      do_op(3'd4, 32'hFFFF_FFEC, 32'd6, 5'd4);
      do_op(3'd6, 32'hFFFF_FFEC, 32'd6, 5'd5);
      do_op(3'd5, 32'd100, 32'd7, 5'd6);
      do_op(3'd7, 32'd100, 32'd7, 5'd7);
      do_op(3'd4, 32'd5, 32'd0, 5'd8);
      do_op(3'd6, 32'd5, 32'd0, 5'd9);
      do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
      do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
      do_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);

      // random operations
      for (int i = 0; i < 40; i++) begin
         rf = 3'($urandom);
         ra = $urandom;
         rb = ($urandom_range(7) == 0) ? 32'd0 :
              ($urandom_range(3) == 0) ? 32'($urandom_range(15)) : $urandom;
         if ($urandom_range(3) == 0) rb = -rb;
         do_op(rf, ra, rb, 5'($urandom));
      end

      // start held high through DONE: one pulse per accepted op
      @(negedge clk);
      start = 1'b1; funct3 = 3'd4; rs1 = 32'd5; rs2 = 32'd0; rd_in = 5'd20;
      @(posedge clk); #1;
      chk("held_done1", {31'b0, done}, 32'd1);
      chk("held_res1", result, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      chk("held_gap_done", {31'b0, done}, 32'd0);
      chk("held_gap_busy", {31'b0, busy}, 32'd0);
      funct3 = 3'd6;
      @(posedge clk); #1;
      chk("held_done2", {31'b0, done}, 32'd1);
      chk("held_res2", result, 32'd5);
      start = 1'b0;
      @(posedge clk); #1;
      chk("held_done_clr", {31'b0, done}, 32'd0);
      last_res = 32'd5;

      // flush in IDLE blocks the start
      @(negedge clk);
      start = 1'b1; flush = 1'b1; funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd3;
      #1 chk("idle_flush_stall", {31'b0, stall}, 32'd0);
      @(posedge clk); #1;
      chk("idle_flush_busy", {31'b0, busy}, 32'd0);
      start = 1'b0; flush = 1'b0;

      // flush at CALC cycle 10
      begin
         logic seen;
         @(negedge clk);
         start = 1'b1; funct3 = 3'd0; rs1 = 32'd9; rs2 = 32'd9; rd_in = 5'd25;
         @(posedge clk); #1 start = 1'b0;
         repeat (9) @(posedge clk);
         @(negedge clk) flush = 1'b1;
         @(posedge clk); #1 flush = 1'b0;
         chk("flush_busy", {31'b0, busy}, 32'd0);
         chk("flush_done", {31'b0, done}, 32'd0);
         seen = 1'b0;
         repeat (40) begin @(posedge clk); #1 if (done) seen = 1'b1; end
         chk("flush_no_pulse", {31'b0, seen}, 32'd0);
         chk("flush_res_hold", result, last_res);

         // reset at CALC cycle 20
         @(negedge clk);
         start = 1'b1; funct3 = 3'd5; rs1 = 32'd1000; rs2 = 32'd3; rd_in = 5'd26;
         @(posedge clk); #1 start = 1'b0;
         repeat (19) @(posedge clk);
         @(negedge clk) reset = 1'b1;
         @(posedge clk); #1 reset = 1'b0;
         chk("rreset_result", result, 32'd0);
         chk("rreset_rd", {27'b0, rd_out}, 32'd0);
         chk("rreset_done", {31'b0, done}, 32'd0);
         chk("rreset_busy", {31'b0, busy}, 32'd0);
         chk("rreset_stall", {31'b0, stall}, 32'd0);
         seen = 1'b0;
         repeat (40) begin @(posedge clk); #1 if (done) seen = 1'b1; end
         chk("rreset_no_pulse", {31'b0, seen}, 32'd0);
      end

      // still functional after mid-op reset
      do_op(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd31);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline register.
- Accepts forwarded operands, funct3 and destination tag for an M-extension instruction held in ID/EX.
- Raises a stall request back to the hazard unit until the result is ready, then presents it to the EX/MEM register alongside the normal ALU result.
- Covers MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.

Parameters:
- XLEN, 32, operand/result width; counter width is clog2(XLEN)+1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- start_i  input  1  ID/EX holds a valid M-op (opcode OP, funct7 = 0000001).
- flush_i  input  1  branch/trap flush; aborts any operation in progress.
- funct3_i  input  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_i  input  XLEN  forwarded operand A (dividend or multiplicand).
- rs2_i  input  XLEN  forwarded operand B (divisor or multiplier).
- addr_rd_i  input  5  destination register.
- result_o  output  XLEN  final result; valid only while done_o = 1.
- addr_rd_o  output  5  latched destination register.
- done_o  output  1  one-cycle result-valid pulse.
- busy_o  output  1  state is not IDLE.
- stall_o  output  1  combinational hold request to the hazard unit: (IDLE & start_i & !flush_i) | CALC.

Behaviour:
- States: IDLE, CALC, DONE.
- Reset:
  - state = IDLE; result_o = 0; addr_rd_o = 0; done_o = 0; busy_o = 0; counter and all datapath registers = 0.
  - Reset has priority over flush_i and start_i.
  - Reset mid-CALC abandons the operation; no done_o pulse follows.
- IDLE, start_i = 1 and flush_i = 0, at the sampling edge E0:
  - Latch funct3, addr_rd and operands.
  - Compute absolute values: signed ops use two's-complement magnitude; MULHSU treats rs1 as signed and rs2 as unsigned; *U ops take operands unchanged.
  - Record the result sign: mult = sign(a) XOR sign(b); quotient = sign(a) XOR sign(b); remainder = sign(a).
  - Go to CALC with cnt = 0, or go directly to DONE on a fast path.
- Fast paths (single-cycle; done_o high in the cycle after E0):
  - Divide by zero: DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU = rs1.
  - Signed overflow (rs1 = 0x80000000, rs2 = 0xFFFFFFFF): DIV = 0x80000000; REM = 0.
- CALC:
  - One iteration per edge; cnt increments each edge.
  - Multiply: shift-add on a 2*XLEN accumulator.
  - Divide: restoring shift-subtract (partial remainder XLEN+1 bits, quotient shifted in LSB-first).
  - After XLEN iterations (edge E32 for XLEN = 32), apply the sign correction (two's-complement negate where the recorded sign is 1) and go to DONE.
  - Normal-path latency is 32 cycles: done_o is high in the cycle after E32.
- Result selection:
  - MUL takes the low XLEN bits of the product.
  - MULH, MULHSU and MULHU take the high XLEN bits.
  - DIV/DIVU take the quotient; REM/REMU take the remainder.
- DONE:
  - done_o = 1 and result_o is valid for exactly one cycle; stall_o = 0, so ID/EX and EX/MEM advance this cycle.
  - Next edge: go to IDLE, done_o = 0.
  - result_o and addr_rd_o hold their values until the next completion.
- start_i is ignored while in CALC or DONE. A new op is accepted only from IDLE, so back-to-back M-ops have a minimum 1-cycle gap (DONE → IDLE).
- flush_i:
  - In CALC or DONE: next state = IDLE, done_o = 0 next cycle, result discarded.
  - In IDLE with start_i = 1: start is not accepted and stall_o = 0.
- Widths: all arithmetic is on unsigned magnitudes. Negating 0x80000000 yields 0x80000000, which is a correct magnitude when treated as unsigned.

Test Plan:
- MUL, rs1 = 7, rs2 = -3 (0xFFFFFFFD) -> stall_o high for 32 cycles; done_o pulses at cycle 32; result_o = 0xFFFFFFEB; addr_rd_o = latched rd.
- MULH 0x80000000 × 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
- DIV -20 / 6 -> 0xFFFFFFFD; REM -20 / 6 -> 0xFFFFFFFE; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2; each done_o at cycle 32.
- DIV 5 / 0 -> 0xFFFFFFFF and REM 5 / 0 -> 5; DIV 0x80000000 / -1 -> 0x80000000 and REM -> 0; all with done_o in the cycle after start.
- start_i held high through DONE -> exactly one done_o pulse; second op accepted only after the IDLE cycle.
- flush_i at cycle 10 of CALC -> busy_o = 0 next cycle, no done_o pulse. Reset at cycle 20 of CALC -> all outputs 0 next cycle, no done_o pulse.
